// File: rtl/latch_write_scheduler_if.sv
// Bus between the requesters and the shared-latch write scheduler.
// The master side is the requester logic (drives req/req_data); the slave
// side is the scheduler, which also owns the shared latch enable and data.
interface latch_write_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       grant;
    logic                  done;
    logic                  busy;
    logic                  latch_en;
    logic [WIDTH-1:0]      latch_d;

    modport master (
        output req, req_data,
        input  grant, done, busy, latch_en, latch_d
    );

    modport slave (
        input  req, req_data,
        output grant, done, busy, latch_en, latch_d
    );
endinterface

// File: rtl/latch_write_scheduler.sv
// Round-robin scheduler sharing one transparent-high data latch among NREQ
// requesters. Each write runs SETUP (data stable, latch closed), OPEN
// (latch transparent for OPEN_CYCLES cycles) and HOLD (latch closed, data
// still stable, done pulse), so the latch never sees its data move while
// it is open or on either side of the open window.
module latch_write_scheduler #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 8,
    parameter int OPEN_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    latch_write_scheduler_if.slave bus
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;

    // A zero-length open window would never make the latch transparent.
    if (OPEN_CYCLES < 1) begin : g_open_cycles_illegal
        $error("latch_write_scheduler: OPEN_CYCLES must be >= 1 (got %0d)", OPEN_CYCLES);
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Registered state and outputs
    state_t            state,    state_n;
    logic [NREQ-1:0]   grant_q,  grant_n;
    logic              done_q,   done_n;
    logic              busy_q,   busy_n;
    logic              en_q,     en_n;
    logic [WIDTH-1:0]  ld_q,     ld_n;
    logic [CNT_W-1:0]  cnt_q,    cnt_n;
    logic [IDX_W-1:0]  rr_ptr,   rr_ptr_n;
    logic [IDX_W-1:0]  win_q,    win_n;

    // Arbitration results
    logic              found;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W-1:0]  idx;

    // Per-requester view of the packed data bus
    logic [WIDTH-1:0]  req_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign req_arr[i] = bus.req_data[i*WIDTH +: WIDTH];
    end

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDX_W'((32'(rr_ptr) + 32'(k)) % 32'(NREQ));
            if (!found && bus.req[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

    // Next-state and next-output logic; outputs are all registered below.
    always_comb begin
        state_n  = state;
        grant_n  = grant_q;
        done_n   = 1'b0;
        busy_n   = busy_q;
        en_n     = 1'b0;
        ld_n     = ld_q;
        cnt_n    = cnt_q;
        rr_ptr_n = rr_ptr;
        win_n    = win_q;

        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n = SETUP;
                    grant_n = NREQ'(1) << win_idx;
                    ld_n    = req_arr[win_idx];
                    busy_n  = 1'b1;
                    win_n   = win_idx;
                end
            end
            SETUP: begin
                state_n = OPEN;
                en_n    = 1'b1;
                cnt_n   = CNT_W'(OPEN_CYCLES - 1);
            end
            OPEN: begin
                if (cnt_q == '0) begin
                    state_n = HOLD;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt_q - 1'b1;
                    en_n  = 1'b1;
                end
            end
            HOLD: begin
                state_n  = IDLE;
                grant_n  = '0;
                busy_n   = 1'b0;
                rr_ptr_n = (win_q == IDX_W'(NREQ - 1)) ? '0 : win_q + 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any write and closes the latch.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            grant_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            ld_q    <= '0;
            cnt_q   <= '0;
            rr_ptr  <= '0;
            win_q   <= '0;
        end else begin
            state   <= state_n;
            grant_q <= grant_n;
            done_q  <= done_n;
            busy_q  <= busy_n;
            en_q    <= en_n;
            ld_q    <= ld_n;
            cnt_q   <= cnt_n;
            rr_ptr  <= rr_ptr_n;
            win_q   <= win_n;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
    assign bus.latch_en = en_q;
    assign bus.latch_d  = ld_q;

    a_en_only_open: assert property (@(posedge clock) disable iff (!reset_n)
        en_q |-> (state == OPEN));
    a_grant_onehot0: assert property (@(posedge clock) disable iff (!reset_n)
        $onehot0(grant_q));
    a_done_granted: assert property (@(posedge clock) disable iff (!reset_n)
        done_q |-> (grant_q != '0));

endmodule

// File: tb/tb_latch_write_scheduler.sv
// Bench for latch_write_scheduler: three instances (OPEN_CYCLES = 2, 1, 5)
// share one stimulus stream; each is compared every cycle against a
// transaction-timeline reference model, with directed table and corner
// sequences on the OPEN_CYCLES=2 instance.
module tb_latch_write_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int NI    = 3;

    logic                  clock = 1'b0;
    logic                  reset_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;

    latch_write_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH)) if_a ();
    latch_write_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH)) if_b ();
    latch_write_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH)) if_c ();

    assign if_a.req = req;  assign if_a.req_data = req_data;
    assign if_b.req = req;  assign if_b.req_data = req_data;
    assign if_c.req = req;  assign if_c.req_data = req_data;

    latch_write_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .OPEN_CYCLES(2)) u_a (
        .clock(clock), .reset_n(reset_n), .bus(if_a.slave));
    latch_write_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .OPEN_CYCLES(1)) u_b (
        .clock(clock), .reset_n(reset_n), .bus(if_b.slave));
    latch_write_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .OPEN_CYCLES(5)) u_c (
        .clock(clock), .reset_n(reset_n), .bus(if_c.slave));

    always #5 clock = ~clock;

    function automatic int oc_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 5);
    endfunction

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Sampled DUT outputs and bench-side latch model
    logic [NREQ-1:0]  s_grant [NI];
    logic             s_en    [NI];
    logic             s_done  [NI];
    logic             s_busy  [NI];
    logic [WIDTH-1:0] s_ld    [NI];
    logic             prev_en [NI];
    logic [WIDTH-1:0] prev_ld [NI];
    logic [WIDTH-1:0] q_dut   [NI];

    // Reference model: a write is a timeline t = 0..OC+1 after the grant edge
    bit               mact [NI];
    int               mt   [NI];
    int               mptr [NI];
    int               mwin [NI];
    logic [WIDTH-1:0] mdat [NI];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic sample();
        s_grant[0] = if_a.grant; s_en[0] = if_a.latch_en; s_done[0] = if_a.done;
        s_busy[0]  = if_a.busy;  s_ld[0] = if_a.latch_d;
        s_grant[1] = if_b.grant; s_en[1] = if_b.latch_en; s_done[1] = if_b.done;
        s_busy[1]  = if_b.busy;  s_ld[1] = if_b.latch_d;
        s_grant[2] = if_c.grant; s_en[2] = if_c.latch_en; s_done[2] = if_c.done;
        s_busy[2]  = if_c.busy;  s_ld[2] = if_c.latch_d;
    endtask

    task automatic model_step();
        bit found;
        int c;
        for (int k = 0; k < NI; k++) begin
            if (!reset_n) begin
                mact[k] = 1'b0; mt[k] = 0; mptr[k] = 0; mwin[k] = 0; mdat[k] = '0;
            end else if (!mact[k]) begin
                if (req != '0) begin
                    found = 1'b0;
                    for (int j = 0; j < NREQ; j++) begin
                        c = (mptr[k] + j) % NREQ;
                        if (!found && req[c]) begin
                            found   = 1'b1;
                            mwin[k] = c;
                        end
                    end
                    mact[k] = 1'b1;
                    mt[k]   = 0;
                    mdat[k] = req_data[mwin[k]*WIDTH +: WIDTH];
                end
            end else begin
                mt[k]++;
                if (mt[k] == oc_of(k) + 2) begin
                    mact[k] = 1'b0;
                    mptr[k] = (mwin[k] + 1) % NREQ;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [NREQ-1:0] eg;
        logic            een, edn;
        int              oc;
        sample();
        for (int k = 0; k < NI; k++) begin
            oc  = oc_of(k);
            eg  = mact[k] ? NREQ'(1 << mwin[k]) : '0;
            een = mact[k] && (mt[k] >= 1) && (mt[k] <= oc);
            edn = mact[k] && (mt[k] == oc + 1);
            chk($sformatf("grant[oc=%0d]", oc),    32'(s_grant[k]), 32'(eg));
            chk($sformatf("latch_en[oc=%0d]", oc), 32'(s_en[k]),    32'(een));
            chk($sformatf("done[oc=%0d]", oc),     32'(s_done[k]),  32'(edn));
            chk($sformatf("busy[oc=%0d]", oc),     32'(s_busy[k]),  32'(mact[k]));
            chk($sformatf("latch_d[oc=%0d]", oc),  32'(s_ld[k]),    32'(mdat[k]));
            if (s_en[k]) q_dut[k] = s_ld[k];
            if (edn) chk($sformatf("q_after_write[oc=%0d]", oc), 32'(q_dut[k]), 32'(mdat[k]));
            if (reset_n && (s_en[k] || prev_en[k]))
                chk($sformatf("latch_d_stable[oc=%0d]", oc), 32'(s_ld[k]), 32'(prev_ld[k]));
            prev_en[k] = s_en[k];
            prev_ld[k] = s_ld[k];
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        cyc++;
        model_step();
        #1;
        check_all();
    endtask

    task automatic wait_grant(output bit got);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            cycle();
            if (if_a.grant != '0) got = 1'b1;
        end
        if (!got) chk("grant_timeout", 32'(got), 32'd1);
    endtask

    task automatic wait_en(output bit got);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            cycle();
            if (if_a.latch_en) got = 1'b1;
        end
        if (!got) chk("latch_en_timeout", 32'(got), 32'd1);
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            cycle();
            if (if_a.done) got = 1'b1;
        end
        if (!got) chk("done_timeout", 32'(got), 32'd1);
    endtask

    typedef struct {
        logic [NREQ-1:0]       req;
        logic [NREQ*WIDTH-1:0] data;
        int                    win;
        logic [WIDTH-1:0]      q;
        bit                    spaced;
        bit                    drop;
    } vec_t;

    vec_t tab [$];

    initial begin
        bit got;
        int last_grant;
        int nd;

        for (int k = 0; k < NI; k++) begin
            prev_en[k] = 1'b0; prev_ld[k] = '0; q_dut[k] = '0;
            mact[k] = 1'b0; mt[k] = 0; mptr[k] = 0; mwin[k] = 0; mdat[k] = '0;
        end

        // Contention from reset: 0,1,2,3,0, five cycles between grants
        tab.push_back('{4'b1111, 32'h4433_2211, 0, 8'h11, 1'b0, 1'b0});
        tab.push_back('{4'b1111, 32'h4433_2211, 1, 8'h22, 1'b1, 1'b0});
        tab.push_back('{4'b1111, 32'h4433_2211, 2, 8'h33, 1'b1, 1'b0});
        tab.push_back('{4'b1111, 32'h4433_2211, 3, 8'h44, 1'b1, 1'b0});
        tab.push_back('{4'b1111, 32'h4433_2211, 0, 8'h11, 1'b1, 1'b1});
        // Single write from requester 2, leaving the pointer at 3
        tab.push_back('{4'b0100, 32'h00A5_0000, 2, 8'hA5, 1'b0, 1'b1});
        // Fairness wrap: 3 first, then 0
        tab.push_back('{4'b1001, 32'h9900_0088, 3, 8'h99, 1'b0, 1'b0});
        tab.push_back('{4'b1001, 32'h9900_0088, 0, 8'h88, 1'b1, 1'b1});

        reset_n  = 1'b0;
        req      = '0;
        req_data = '0;
        cycle();
        cycle();
        chk("reset_grant", 32'(if_a.grant), 32'd0);
        chk("reset_busy",  32'(if_a.busy),  32'd0);
        reset_n = 1'b1;
        cycle();

        last_grant = 0;
        for (int i = 0; i < tab.size(); i++) begin
            req      = tab[i].req;
            req_data = tab[i].data;
            wait_grant(got);
            chk($sformatf("tab%0d_grant", i), 32'(if_a.grant), 32'(1 << tab[i].win));
            if (tab[i].spaced) chk($sformatf("tab%0d_spacing", i), 32'(cyc - last_grant), 32'd5);
            last_grant = cyc;
            wait_done(got);
            chk($sformatf("tab%0d_q", i), 32'(q_dut[0]), 32'(tab[i].q));
            cycle();
            if (tab[i].drop) begin
                req = '0;
                cycle();
            end
        end

        // Data stability: data changes and req drops while the latch is open
        req      = 4'b0010;
        req_data = 32'h0000_5A00;
        wait_grant(got);
        chk("stab_grant", 32'(if_a.grant), 32'b0010);
        wait_en(got);
        req_data = 32'hFFFF_FFFF;
        req      = '0;
        wait_done(got);
        chk("stab_latch_d", 32'(if_a.latch_d), 32'h5A);
        chk("stab_q",       32'(q_dut[0]),     32'h5A);
        nd = 0;
        repeat (6) begin
            cycle();
            if (if_a.done) nd++;
        end
        chk("stab_single_done", 32'(nd), 32'd0);

        // Asynchronous reset in the middle of the open window
        req      = 4'b0001;
        req_data = 32'h0000_0077;
        wait_grant(got);
        chk("rst_pre_grant", 32'(if_a.grant), 32'b0001);
        wait_en(got);
        reset_n = 1'b0;
        req     = '0;
        #1;
        chk("async_rst_grant",    32'(if_a.grant),    32'd0);
        chk("async_rst_latch_en", 32'(if_a.latch_en), 32'd0);
        chk("async_rst_busy",     32'(if_a.busy),     32'd0);
        chk("async_rst_done",     32'(if_a.done),     32'd0);
        chk("async_rst_latch_d",  32'(if_a.latch_d),  32'd0);
        cycle();
        cycle();
        reset_n = 1'b1;
        nd = 0;
        repeat (6) begin
            cycle();
            if (if_a.done) nd++;
        end
        chk("no_done_after_reset", 32'(nd), 32'd0);
        req      = 4'b1111;
        req_data = 32'h4433_2211;
        wait_grant(got);
        chk("post_reset_first_grant", 32'(if_a.grant), 32'b0001);
        wait_done(got);
        cycle();
        req = '0;
        cycle();

        // Random requests on all three instances against the model
        for (int i = 0; i < 1000; i++) begin
            req = NREQ'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req_data = $urandom;
            cycle();
        end
        req = '0;
        repeat (10) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
